uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 868, giving clk cycles per UART bit (100 MHz / 115200).
REQ-002 The block SHALL have parameter ADDR_W, default 14, giving the word-address width of the target memory.
REQ-003 The block SHALL have parameter DEPTH, default 16384, giving the maximum loadable word count.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  sole clock, all state updated on rising edge.
REQ-005 The block SHALL have rst_a  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have start  input  1  arm request, sampled on clk.
REQ-007 The block SHALL have rx  input  1  UART serial in, asynchronous, idle high.
REQ-008 The block SHALL have prog_we  output  1  one-cycle word write strobe to instruction/data memory.
REQ-009 The block SHALL have prog_addr  output  ADDR_W  word address of the current write.
REQ-010 The block SHALL have prog_wdata  output  32  word data of the current write.
REQ-011 The block SHALL have busy  output  1  load in progress; the CPU is held in reset while this is high.
REQ-012 The block SHALL have done, frame_err and len_err  output  1 each  sticky status flags.

Function
REQ-013 The rx input SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-014 Byte receiver, 8N1 format, LSB first, states RX_IDLE/START/DATA/STOP:
- a falling edge in RX_IDLE enters START;
- START SHALL re-sample rx after CLK_DIV/2 cycles; high means false start, return to RX_IDLE with no byte;
- DATA SHALL sample 8 bits at CLK_DIV-cycle spacing;
- STOP samples CLK_DIV cycles after the last data sample.
REQ-015 A stop sample of 1 SHALL yield a one-cycle internal byte_valid; a stop sample of 0 SHALL raise frame_err and discard the byte.
REQ-016 Loader FSM states SHALL be IDLE, HDR, LOAD, DONE, ERR.
REQ-017 IDLE/DONE/ERR: start=1 SHALL enter HDR, clear done/frame_err/len_err, and zero the word index and byte index; busy=1 from the following cycle.
REQ-018 HDR: two received bytes SHALL form word count N, little-endian (first byte = N[7:0]).
REQ-019 After the header, HDR SHALL transition as follows:
- N=0: DONE on the cycle after the second byte_valid;
- N>DEPTH: ERR with len_err=1;
- otherwise: LOAD.
REQ-020 LOAD: bytes SHALL assemble little-endian, prog_wdata = {b3,b2,b1,b0}.
REQ-021 prog_we SHALL pulse high exactly one cycle, the cycle after the 4th byte's byte_valid.
REQ-022 prog_addr SHALL equal the word index (starting at 0) during the pulse; the index SHALL increment after the pulse.
REQ-023 After word N-1 is written, the FSM SHALL enter DONE: done=1, busy=0.
REQ-024 frame_err in HDR or LOAD SHALL enter ERR with busy=0; a partially assembled word SHALL NOT be written.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 Bytes arriving in IDLE, DONE or ERR SHALL be received and discarded, with no flag change.
REQ-027 prog_addr and prog_wdata SHALL hold their last value when prog_we=0.
REQ-028 The word index SHALL never exceed DEPTH-1 and no wrap-around write SHALL occur.

Reset
REQ-029 rst_a=0 SHALL asynchronously force:
- loader FSM to IDLE and receiver to RX_IDLE;
- synchronizer flops to 1;
- all counters to 0;
- prog_we, prog_addr, prog_wdata, busy, done, frame_err, len_err to 0.
REQ-030 Reset asserted mid-load SHALL abort the load with no further prog_we; after release, a new start SHALL reload from address 0.

Verification (CLK_DIV=8)
REQ-031 Reset: hold rst_a=0 with rx toggling -> all outputs 0; no prog_we after release without start.
REQ-032 Two-word load: start, send 02 00 78 56 34 12 EF BE AD DE -> prog_we at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF; done=1, busy=0; exactly 2 strobes.
REQ-033 Empty load: start, send 00 00 -> done=1 one cycle after the 2nd byte; no prog_we.
REQ-034 Framing error: N=1, 3rd data byte sent with stop bit 0 -> frame_err=1, busy=0, no prog_we; the following start clears frame_err.
REQ-035 Glitch and oversize: rx low for 2 cycles -> no byte; header N=DEPTH+1 -> len_err=1, no prog_we.
REQ-036 Reset mid-word after 2 payload bytes -> no write; re-arm and send 01 00 44 33 22 11 -> addr 0 data 0x11223344, done=1.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a little-endian word count followed by
// 32-bit little-endian words over 8N1 UART and streams them into a
// program memory, holding the CPU in reset (busy) while loading.
//
// Loader states
//   state | meaning
//   IDLE  | waiting for start, incoming bytes discarded
//   HDR   | collecting the two-byte word count
//   LOAD  | assembling and writing payload words
//   DONE  | load complete, done flag set
//   ERR   | load aborted by framing error or oversize count
//
// Receiver states
//   state   | meaning
//   RX_IDLE | line idle, watching for a falling edge
//   START   | half-bit wait, confirm start bit is still low
//   DATA    | sampling 8 data bits LSB first
//   STOP    | sampling the stop bit
module uart_prog_loader #(
  parameter int CLK_DIV = 868,
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 16384
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              start,
  input  logic              rx,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic              len_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} ld_state_t;

  rx_state_t        rx_state, rx_next;
  ld_state_t        state, state_next;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_tick;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             byte_valid, rx_ferr;
  logic [1:0]       byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]       hdr_lo;
  logic [15:0]      hdr_n;
  logic [15:0]      n_full;
  logic [23:0]      word_buf;
  logic             err_len;
  logic             last_word;

  assign baud_tick = (baud_cnt == '0);
  assign n_full    = {rx_shift, hdr_lo};
  assign last_word = (32'(word_idx) == (32'(hdr_n) - 32'd1));

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next-state logic
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s2) rx_next = START;
      START:   if (baud_tick) rx_next = rx_s2 ? RX_IDLE : DATA;
      DATA:    if (baud_tick && bit_cnt == 3'd7) rx_next = STOP;
      STOP:    if (baud_tick) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // Receiver outputs: one-cycle byte strobe or framing-error strobe at the stop sample
  always_comb begin
    byte_valid = 1'b0;
    rx_ferr    = 1'b0;
    if (rx_state == STOP && baud_tick) begin
      byte_valid = rx_s2;
      rx_ferr    = !rx_s2;
    end
  end

  // Receiver bit timer (down-counter reloaded at each sample) and shift register
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          baud_cnt <= HALF_LAST;
          bit_cnt  <= '0;
        end
        START: baud_cnt <= baud_tick ? BIT_LAST : baud_cnt - CNT_W'(1);
        DATA: begin
          if (baud_tick) begin
            baud_cnt <= BIT_LAST;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        STOP: baud_cnt <= baud_tick ? HALF_LAST : baud_cnt - CNT_W'(1);
        default: baud_cnt <= HALF_LAST;
      endcase
    end
  end

  // Loader state register
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) state <= IDLE;
    else        state <= state_next;
  end

  // Loader next-state logic; start is only honoured when not busy
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = HDR;
      HDR: begin
        if (rx_ferr) state_next = ERR;
        else if (byte_valid && byte_idx == 2'd1) begin
          if (n_full == 16'd0)                state_next = DONE;
          else if (32'(n_full) > 32'(DEPTH))  state_next = ERR;
          else                                state_next = LOAD;
        end
      end
      LOAD: begin
        if (rx_ferr) state_next = ERR;
        else if (byte_valid && byte_idx == 2'd3 && last_word) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Loader status outputs decoded from state; err_len picks which error flag shows
  always_comb begin
    busy      = (state == HDR) || (state == LOAD);
    done      = (state == DONE);
    frame_err = (state == ERR) && !err_len;
    len_err   = (state == ERR) && err_len;
  end

  // Loader datapath: header capture, word assembly and memory write strobe
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      byte_idx   <= '0;
      word_idx   <= '0;
      hdr_lo     <= '0;
      hdr_n      <= '0;
      word_buf   <= '0;
      err_len    <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            byte_idx <= '0;
            word_idx <= '0;
            err_len  <= 1'b0;
          end
        end
        HDR: begin
          if (byte_valid) begin
            if (byte_idx == 2'd0) begin
              hdr_lo   <= rx_shift;
              byte_idx <= 2'd1;
            end else begin
              hdr_n    <= n_full;
              byte_idx <= 2'd0;
              err_len  <= (32'(n_full) > 32'(DEPTH));
            end
          end
        end
        LOAD: begin
          if (byte_valid) begin
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_shift;
              2'd1: word_buf[15:8]  <= rx_shift;
              2'd2: word_buf[23:16] <= rx_shift;
              default: begin
                prog_we    <= 1'b1;
                prog_addr  <= word_idx;
                prog_wdata <= {rx_shift, word_buf};
                // Index stays put on the final word so it never reaches DEPTH
                if (!last_word) word_idx <= word_idx + ADDR_W'(1);
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a write scoreboard.
module tb_uart_prog_loader;

  localparam int CLK_DIV = 8;
  localparam int ADDR_W  = 14;
  localparam int DEPTH   = 16384;

  logic              clk = 1'b0;
  logic              rst_a = 1'b0;
  logic              start = 1'b0;
  logic              rx = 1'b1;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_wdata;
  logic              busy, done, frame_err, len_err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  int  checks  = 0;
  int  errors  = 0;
  int  strobes = 0;
  int  base    = 0;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_a(rst_a), .start(start), .rx(rx),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .busy(busy), .done(done), .frame_err(frame_err), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({prog_we, prog_addr, prog_wdata, busy, done, frame_err, len_err}), 64'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic chk_timing);
    rx = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CLK_DIV);
    end
    rx = stop_bit;
    for (int k = 1; k <= CLK_DIV; k++) begin
      tick(1);
      if (chk_timing && k == 6) chk("done_before_edge", 64'(done), 64'd0);
      if (chk_timing && k == 7) chk("done_at_edge", 64'(done), 64'd1);
    end
    rx = 1'b1;
    tick(2);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_a && prog_we) begin
      wr_t e;
      strobes++;
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 64'(prog_addr), 64'(e.addr));
        chk("wr_data", 64'(prog_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    // Reset held with rx toggling
    for (int i = 0; i < 20; i++) begin
      rx = i[0];
      tick(1);
    end
    chk_zero("reset_hold");
    rx = 1'b1;
    tick(1);
    rst_a = 1'b1;
    tick(60);
    chk("no_we_after_reset", 64'(strobes), 64'd0);
    chk_zero("idle_after_reset");

    // Two-word load, with a start pulse mid-load that must be ignored
    base = strobes;
    pulse_start;
    chk("busy_after_start", 64'(busy), 64'd1);
    sb.push_back('{14'd0, 32'h12345678});
    sb.push_back('{14'd1, 32'hDEADBEEF});
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    pulse_start;
    chk("busy_start_ignored", 64'(busy), 64'd1);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    tick(2);
    chk("two_done", 64'(done), 64'd1);
    chk("two_busy", 64'(busy), 64'd0);
    chk("two_strobes", 64'(strobes - base), 64'd2);
    chk("two_sb_empty", 64'(sb.size()), 64'd0);
    tick(10);
    chk("hold_addr", 64'(prog_addr), 64'd1);
    chk("hold_data", 64'(prog_wdata), 64'hDEADBEEF);
    send(8'h55);
    chk("byte_in_done_flags", 64'({done, busy, frame_err, len_err}), 64'b1000);

    // Empty load: done exactly one cycle after the second byte strobe
    base = strobes;
    pulse_start;
    chk("empty_done_cleared", 64'(done), 64'd0);
    send(8'h00);
    send_frame(8'h00, 1'b1, 1'b1);
    chk("empty_busy", 64'(busy), 64'd0);
    chk("empty_strobes", 64'(strobes - base), 64'd0);

    // Framing error on the third payload byte of a one-word load
    base = strobes;
    pulse_start;
    send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB);
    send_frame(8'hCC, 1'b0, 1'b0);
    chk("ferr_flag", 64'(frame_err), 64'd1);
    chk("ferr_busy", 64'(busy), 64'd0);
    chk("ferr_other_flags", 64'({done, len_err}), 64'd0);
    chk("ferr_strobes", 64'(strobes - base), 64'd0);
    pulse_start;
    chk("ferr_cleared", 64'(frame_err), 64'd0);
    chk("ferr_rearm_busy", 64'(busy), 64'd1);
    send(8'h00); send(8'h00);
    chk("ferr_recover_done", 64'(done), 64'd1);

    // Glitch in HDR must not produce a byte; then oversize count
    base = strobes;
    pulse_start;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    send(8'h01); send(8'h40);
    chk("len_err_flag", 64'(len_err), 64'd1);
    chk("len_err_busy", 64'(busy), 64'd0);
    chk("len_err_ferr", 64'(frame_err), 64'd0);
    chk("len_err_strobes", 64'(strobes - base), 64'd0);

    // Count equal to DEPTH is accepted; reset mid-word aborts the load
    base = strobes;
    pulse_start;
    send(8'h00); send(8'h40);
    chk("n_depth_busy", 64'(busy), 64'd1);
    chk("n_depth_no_len_err", 64'(len_err), 64'd0);
    send(8'h99); send(8'h88);
    rst_a = 1'b0;
    #1;
    chk_zero("reset_mid_load");
    tick(3);
    rst_a = 1'b1;
    tick(100);
    chk("reset_mid_strobes", 64'(strobes - base), 64'd0);

    // Reload from address 0 after reset
    base = strobes;
    pulse_start;
    sb.push_back('{14'd0, 32'h11223344});
    send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    tick(2);
    chk("reload_done", 64'(done), 64'd1);
    chk("reload_busy", 64'(busy), 64'd0);
    chk("reload_strobes", 64'(strobes - base), 64'd1);
    chk("reload_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
